// File: rtl/reservation_station.sv
// ALU reservation station: buffers dispatched instructions, snoops the ALU and
// LSB result buses for pending operands and sends one ready entry per cycle.
module reservation_station #(
    parameter int SIZE  = 16,
    parameter int IDX_W = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic        issue_valid,
    input  logic [5:0]  issue_opcode,
    input  logic        issue_q1_busy,
    input  logic        issue_q2_busy,
    input  logic [5:0]  issue_q1,
    input  logic [5:0]  issue_q2,
    input  logic [31:0] issue_val1,
    input  logic [31:0] issue_val2,
    input  logic [31:0] issue_imm,
    input  logic [31:0] issue_pc,
    input  logic [5:0]  issue_rob_index,
    input  logic        alu_cdb_valid,
    input  logic        lsb_cdb_valid,
    input  logic [5:0]  alu_cdb_rob_index,
    input  logic [5:0]  lsb_cdb_rob_index,
    input  logic [31:0] alu_cdb_res,
    input  logic [31:0] lsb_cdb_res,
    output logic        full,
    output logic [5:0]  alu_opcode,
    output logic [31:0] alu_val1,
    output logic [31:0] alu_val2,
    output logic [31:0] alu_imm,
    output logic [31:0] alu_pc,
    output logic [5:0]  alu_rob_index
);

    logic [SIZE-1:0] busy_reg;
    logic [SIZE-1:0] q1_busy_reg;
    logic [SIZE-1:0] q2_busy_reg;
    logic [5:0]      opcode_reg [SIZE];
    logic [5:0]      q1_reg     [SIZE];
    logic [5:0]      q2_reg     [SIZE];
    logic [31:0]     val1_reg   [SIZE];
    logic [31:0]     val2_reg   [SIZE];
    logic [31:0]     imm_reg    [SIZE];
    logic [31:0]     pc_reg     [SIZE];
    logic [5:0]      rob_reg    [SIZE];

    logic [SIZE-1:0]  ready;
    logic [SIZE-1:0]  w1_alu, w1_lsb, w2_alu, w2_lsb;
    logic [IDX_W-1:0] free_idx, sel_idx;
    logic             any_ready, active, do_issue;
    logic             iss_q1_busy, iss_q2_busy;
    logic [31:0]      iss_val1, iss_val2;

    assign full      = &busy_reg;
    assign any_ready = |ready;
    assign active    = rdy_in & ~clear;
    assign do_issue  = active & issue_valid & ~full;

    genvar gi;
    generate
        for (gi = 0; gi < SIZE; gi++) begin : g_entry
            // Readiness uses registered state only; a same-cycle CDB lands next cycle.
            assign ready[gi]  = busy_reg[gi] & ~q1_busy_reg[gi] & ~q2_busy_reg[gi];
            assign w1_alu[gi] = q1_busy_reg[gi] & alu_cdb_valid & (alu_cdb_rob_index == q1_reg[gi]);
            assign w1_lsb[gi] = q1_busy_reg[gi] & lsb_cdb_valid & (lsb_cdb_rob_index == q1_reg[gi]);
            assign w2_alu[gi] = q2_busy_reg[gi] & alu_cdb_valid & (alu_cdb_rob_index == q2_reg[gi]);
            assign w2_lsb[gi] = q2_busy_reg[gi] & lsb_cdb_valid & (lsb_cdb_rob_index == q2_reg[gi]);
        end
    endgenerate

    // Lowest-index free slot and lowest-index ready slot.
    always_comb begin
        free_idx = '0;
        sel_idx  = '0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (!busy_reg[i]) free_idx = IDX_W'(i);
            if (ready[i])     sel_idx  = IDX_W'(i);
        end
    end

    // Operands arriving on a CDB in the issue cycle are captured directly.
    always_comb begin
        iss_q1_busy = issue_q1_busy;
        iss_val1    = issue_val1;
        iss_q2_busy = issue_q2_busy;
        iss_val2    = issue_val2;
        if (issue_q1_busy && alu_cdb_valid && alu_cdb_rob_index == issue_q1) begin
            iss_q1_busy = 1'b0;
            iss_val1    = alu_cdb_res;
        end else if (issue_q1_busy && lsb_cdb_valid && lsb_cdb_rob_index == issue_q1) begin
            iss_q1_busy = 1'b0;
            iss_val1    = lsb_cdb_res;
        end
        if (issue_q2_busy && alu_cdb_valid && alu_cdb_rob_index == issue_q2) begin
            iss_q2_busy = 1'b0;
            iss_val2    = alu_cdb_res;
        end else if (issue_q2_busy && lsb_cdb_valid && lsb_cdb_rob_index == issue_q2) begin
            iss_q2_busy = 1'b0;
            iss_val2    = lsb_cdb_res;
        end
    end

    // Entry payload needs no reset: it is only observed while busy is set.
    always_ff @(posedge clk_in) begin
        if (active) begin
            for (int i = 0; i < SIZE; i++) begin
                if (busy_reg[i]) begin
                    if (w1_alu[i]) begin
                        val1_reg[i]    <= alu_cdb_res;
                        q1_busy_reg[i] <= 1'b0;
                    end else if (w1_lsb[i]) begin
                        val1_reg[i]    <= lsb_cdb_res;
                        q1_busy_reg[i] <= 1'b0;
                    end
                    if (w2_alu[i]) begin
                        val2_reg[i]    <= alu_cdb_res;
                        q2_busy_reg[i] <= 1'b0;
                    end else if (w2_lsb[i]) begin
                        val2_reg[i]    <= lsb_cdb_res;
                        q2_busy_reg[i] <= 1'b0;
                    end
                end
            end
            if (do_issue) begin
                opcode_reg[free_idx]  <= issue_opcode;
                q1_busy_reg[free_idx] <= iss_q1_busy;
                q1_reg[free_idx]      <= issue_q1;
                val1_reg[free_idx]    <= iss_val1;
                q2_busy_reg[free_idx] <= iss_q2_busy;
                q2_reg[free_idx]      <= issue_q2;
                val2_reg[free_idx]    <= iss_val2;
                imm_reg[free_idx]     <= issue_imm;
                pc_reg[free_idx]      <= issue_pc;
                rob_reg[free_idx]     <= issue_rob_index;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_reg      <= '0;
            alu_opcode    <= '0;
            alu_val1      <= '0;
            alu_val2      <= '0;
            alu_imm       <= '0;
            alu_pc        <= '0;
            alu_rob_index <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                busy_reg   <= '0;
                alu_opcode <= '0;
            end else begin
                if (any_ready) begin
                    busy_reg[sel_idx] <= 1'b0;
                    alu_opcode        <= opcode_reg[sel_idx];
                    alu_val1          <= val1_reg[sel_idx];
                    alu_val2          <= val2_reg[sel_idx];
                    alu_imm           <= imm_reg[sel_idx];
                    alu_pc            <= pc_reg[sel_idx];
                    alu_rob_index     <= rob_reg[sel_idx];
                end else begin
                    alu_opcode <= '0;
                end
                // Free slot was idle at cycle start, so it never collides with sel_idx.
                if (do_issue) busy_reg[free_idx] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: table-driven vectors, directed multi-cycle
// sequences, and randomized traffic against a slot-level reference model.
module tb_reservation_station;

    localparam logic [5:0] OP_ADD = 6'd1;
    localparam logic [5:0] OP_SUB = 6'd2;
    localparam logic [5:0] OP_XOR = 6'd5;
    localparam logic [5:0] OP_OR  = 6'd6;
    localparam logic [5:0] OP_AND = 6'd7;
    localparam logic [5:0] OP_BEQ = 6'd20;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear, issue_valid;
    logic [5:0]  issue_opcode, issue_q1, issue_q2, issue_rob_index;
    logic        issue_q1_busy, issue_q2_busy;
    logic [31:0] issue_val1, issue_val2, issue_imm, issue_pc;
    logic        alu_cdb_valid, lsb_cdb_valid;
    logic [5:0]  alu_cdb_rob_index, lsb_cdb_rob_index;
    logic [31:0] alu_cdb_res, lsb_cdb_res;
    logic        full;
    logic [5:0]  alu_opcode, alu_rob_index;
    logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;

    int n_cmp = 0;
    int n_err = 0;

    reservation_station #(.SIZE(16), .IDX_W(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .issue_valid(issue_valid), .issue_opcode(issue_opcode),
        .issue_q1_busy(issue_q1_busy), .issue_q2_busy(issue_q2_busy),
        .issue_q1(issue_q1), .issue_q2(issue_q2),
        .issue_val1(issue_val1), .issue_val2(issue_val2),
        .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_rob_index(issue_rob_index),
        .alu_cdb_valid(alu_cdb_valid), .lsb_cdb_valid(lsb_cdb_valid),
        .alu_cdb_rob_index(alu_cdb_rob_index), .lsb_cdb_rob_index(lsb_cdb_rob_index),
        .alu_cdb_res(alu_cdb_res), .lsb_cdb_res(lsb_cdb_res),
        .full(full), .alu_opcode(alu_opcode), .alu_val1(alu_val1), .alu_val2(alu_val2),
        .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob_index(alu_rob_index)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Directed packets carry imm = rob+100 and pc = 0x1000 + 4*rob.
    task automatic check_pkt(input string name, input logic [5:0] op, input logic [31:0] v1,
                             input logic [31:0] v2, input logic [5:0] rob);
        check({name, ".op"}, 32'(alu_opcode), 32'(op));
        if (op != 6'd0) begin
            check({name, ".val1"}, alu_val1, v1);
            check({name, ".val2"}, alu_val2, v2);
            check({name, ".rob"}, 32'(alu_rob_index), 32'(rob));
            check({name, ".imm"}, alu_imm, 32'(rob) + 32'd100);
            check({name, ".pc"}, alu_pc, 32'h1000 + 32'(rob) * 32'd4);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive_idle();
        rdy_in = 1'b1; clear = 1'b0; issue_valid = 1'b0; issue_opcode = '0;
        issue_q1_busy = 1'b0; issue_q2_busy = 1'b0; issue_q1 = '0; issue_q2 = '0;
        issue_val1 = '0; issue_val2 = '0; issue_imm = '0; issue_pc = '0; issue_rob_index = '0;
        alu_cdb_valid = 1'b0; lsb_cdb_valid = 1'b0; alu_cdb_rob_index = '0;
        lsb_cdb_rob_index = '0; alu_cdb_res = '0; lsb_cdb_res = '0;
    endtask

    task automatic drive_issue(input logic [5:0] op, input logic b1, input logic [5:0] q1,
                               input logic [31:0] v1, input logic b2, input logic [5:0] q2,
                               input logic [31:0] v2, input logic [5:0] rob);
        issue_valid = 1'b1; issue_opcode = op;
        issue_q1_busy = b1; issue_q1 = q1; issue_val1 = v1;
        issue_q2_busy = b2; issue_q2 = q2; issue_val2 = v2;
        issue_rob_index = rob;
        issue_imm = 32'(rob) + 32'd100;
        issue_pc  = 32'h1000 + 32'(rob) * 32'd4;
    endtask

    // ---------------- table-driven vectors ----------------
    typedef struct {
        logic iv; logic [5:0] op; logic b1; logic [5:0] q1; logic [31:0] v1;
        logic b2; logic [5:0] q2; logic [31:0] v2; logic [5:0] rob;
        logic av; logic [5:0] at; logic [31:0] ar;
        logic lv; logic [5:0] lt; logic [31:0] lr;
        logic [5:0] e_op; logic [31:0] e_v1; logic [31:0] e_v2; logic [5:0] e_rob;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic iv, input logic [5:0] op, input logic b1,
            input logic [5:0] q1, input logic [31:0] v1, input logic b2, input logic [5:0] q2,
            input logic [31:0] v2, input logic [5:0] rob, input logic av, input logic [5:0] at,
            input logic [31:0] ar, input logic lv, input logic [5:0] lt, input logic [31:0] lr,
            input logic [5:0] e_op, input logic [31:0] e_v1, input logic [31:0] e_v2,
            input logic [5:0] e_rob);
        vec_t r;
        r = '{iv, op, b1, q1, v1, b2, q2, v2, rob, av, at, ar, lv, lt, lr, e_op, e_v1, e_v2, e_rob};
        return r;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        bit busy; logic [5:0] op; bit p1; bit p2; logic [5:0] t1; logic [5:0] t2;
        logic [31:0] v1; logic [31:0] v2; logic [31:0] imm; logic [31:0] pc; logic [5:0] rob;
    } ment_t;

    ment_t m[16];
    logic [5:0]  e_op, e_rob;
    logic [31:0] e_v1, e_v2, e_imm, e_pc;

    function automatic logic [32:0] snoop(input logic p, input logic [5:0] t, input logic [31:0] v);
        if (p && alu_cdb_valid && alu_cdb_rob_index == t) return {1'b0, alu_cdb_res};
        if (p && lsb_cdb_valid && lsb_cdb_rob_index == t) return {1'b0, lsb_cdb_res};
        return {p, v};
    endfunction

    function automatic logic model_full();
        foreach (m[i]) if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        foreach (m[i]) m[i].busy = 1'b0;
        e_op = '0; e_v1 = '0; e_v2 = '0; e_imm = '0; e_pc = '0; e_rob = '0;
    endtask

    // Advance the model across one clock edge using the currently driven inputs.
    task automatic model_step();
        int sel, fr;
        if (!rdy_in) return;
        if (clear) begin
            foreach (m[i]) m[i].busy = 1'b0;
            e_op = '0;
            return;
        end
        sel = -1; fr = -1;
        foreach (m[i]) begin
            if (sel < 0 && m[i].busy && !m[i].p1 && !m[i].p2) sel = i;
            if (fr < 0 && !m[i].busy) fr = i;
        end
        foreach (m[i]) begin
            if (m[i].busy) begin
                {m[i].p1, m[i].v1} = snoop(m[i].p1, m[i].t1, m[i].v1);
                {m[i].p2, m[i].v2} = snoop(m[i].p2, m[i].t2, m[i].v2);
            end
        end
        if (sel >= 0) begin
            e_op = m[sel].op; e_v1 = m[sel].v1; e_v2 = m[sel].v2;
            e_imm = m[sel].imm; e_pc = m[sel].pc; e_rob = m[sel].rob;
            m[sel].busy = 1'b0;
        end else begin
            e_op = '0;
        end
        if (issue_valid && fr >= 0) begin
            m[fr].busy = 1'b1; m[fr].op = issue_opcode;
            m[fr].t1 = issue_q1; m[fr].t2 = issue_q2;
            {m[fr].p1, m[fr].v1} = snoop(issue_q1_busy, issue_q1, issue_val1);
            {m[fr].p2, m[fr].v2} = snoop(issue_q2_busy, issue_q2, issue_val2);
            m[fr].imm = issue_imm; m[fr].pc = issue_pc; m[fr].rob = issue_rob_index;
        end
    endtask

    initial begin
        int cdb_pct;

        // Reset state
        drive_idle();
        rst_in = 1'b1;
        #2;
        check("reset.op", 32'(alu_opcode), 0);
        check("reset.val1", alu_val1, 0);
        check("reset.full", 32'(full), 0);
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;

        vt.push_back(mk(1, OP_ADD, 0, 0, 5, 0, 0, 7, 3,   0, 0, 0, 0, 0, 0,                 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0,                 OP_ADD, 5, 7, 3));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0,                 0, 0, 0, 0));
        vt.push_back(mk(1, OP_BEQ, 1, 9, 0, 0, 0, 4, 5,   0, 0, 0, 0, 0, 0,                 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,        1, 8, 32'h77, 0, 0, 0,            0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 1, 9, 4,                 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0,                 OP_BEQ, 4, 4, 5));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0,                 0, 0, 0, 0));
        vt.push_back(mk(1, OP_SUB, 0, 0, 11, 1, 12, 0, 7, 1, 12, 32'h80000000, 1, 12, 32'h1234, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0,                 OP_SUB, 11, 32'h80000000, 7));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0,                 0, 0, 0, 0));
        vt.push_back(mk(1, OP_XOR, 1, 0, 0, 0, 0, 3, 0,   0, 0, 0, 0, 0, 0,                 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,        1, 0, 32'h55, 1, 0, 32'h66,       0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0,                 OP_XOR, 32'h55, 3, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0,                 0, 0, 0, 0));
        vt.push_back(mk(1, OP_OR, 1, 20, 0, 1, 21, 0, 9,  0, 0, 0, 0, 0, 0,                 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,        1, 21, 32'hA, 1, 20, 32'hB,       0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0,                 OP_OR, 32'hB, 32'hA, 9));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0,                 0, 0, 0, 0));
        vt.push_back(mk(1, OP_AND, 0, 0, 1, 0, 0, 2, 10,  0, 0, 0, 0, 0, 0,                 0, 0, 0, 0));
        vt.push_back(mk(1, OP_AND, 0, 0, 3, 0, 0, 4, 11,  0, 0, 0, 0, 0, 0,                 OP_AND, 1, 2, 10));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0,                 OP_AND, 3, 4, 11));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0,                 0, 0, 0, 0));

        foreach (vt[k]) begin
            drive_idle();
            if (vt[k].iv)
                drive_issue(vt[k].op, vt[k].b1, vt[k].q1, vt[k].v1, vt[k].b2, vt[k].q2, vt[k].v2, vt[k].rob);
            alu_cdb_valid = vt[k].av; alu_cdb_rob_index = vt[k].at; alu_cdb_res = vt[k].ar;
            lsb_cdb_valid = vt[k].lv; lsb_cdb_rob_index = vt[k].lt; lsb_cdb_res = vt[k].lr;
            cyc();
            $display("vec %0d: alu_opcode=%0d val1=%h val2=%h rob=%0d", k, alu_opcode, alu_val1, alu_val2, alu_rob_index);
            check_pkt($sformatf("vec%0d", k), vt[k].e_op, vt[k].e_v1, vt[k].e_v2, vt[k].e_rob);
        end

        // Asynchronous reset mid-cycle while outputs hold nonzero values
        drive_idle();
        @(posedge clk_in);
        #3 rst_in = 1'b1;
        #1;
        $display("async reset: alu_opcode=%0d val1=%h rob=%0d full=%0b", alu_opcode, alu_val1, alu_rob_index, full);
        check("areset.op", 32'(alu_opcode), 0);
        check("areset.val1", alu_val1, 0);
        check("areset.val2", alu_val2, 0);
        check("areset.imm", alu_imm, 0);
        check("areset.pc", alu_pc, 0);
        check("areset.rob", 32'(alu_rob_index), 0);
        check("areset.full", 32'(full), 0);
        @(posedge clk_in);
        #1 rst_in = 1'b0;

        // Fill all 16 slots waiting on tag 1, then a 17th issue that must be dropped
        for (int i = 0; i < 16; i++) begin
            drive_idle();
            drive_issue(OP_ADD, 1, 1, 0, 0, 0, i, 6'(i));
            check($sformatf("fill%0d.full_before", i), 32'(full), 0);
            cyc();
            $display("fill %0d: full=%0b alu_opcode=%0d", i, full, alu_opcode);
            check($sformatf("fill%0d.op", i), 32'(alu_opcode), 0);
        end
        check("full.set", 32'(full), 1);
        drive_issue(OP_SUB, 0, 0, 1, 0, 0, 2, 40);
        cyc();
        check("full.17th_op", 32'(alu_opcode), 0);
        check("full.still", 32'(full), 1);
        drive_idle();
        alu_cdb_valid = 1'b1; alu_cdb_rob_index = 6'd1; alu_cdb_res = 32'h100;
        cyc();
        check("full.bcast_op", 32'(alu_opcode), 0);
        check("full.bcast_full", 32'(full), 1);
        drive_idle();
        for (int i = 0; i < 16; i++) begin
            cyc();
            $display("drain %0d: alu_opcode=%0d rob=%0d full=%0b", i, alu_opcode, alu_rob_index, full);
            check_pkt($sformatf("drain%0d", i), OP_ADD, 32'h100, i, 6'(i));
            check($sformatf("drain%0d.full", i), 32'(full), 0);
        end
        cyc();
        check("drain.after", 32'(alu_opcode), 0);

        // Clear with a simultaneous issue: nothing held or newly issued may leave
        for (int i = 0; i < 3; i++) begin
            drive_idle();
            drive_issue(OP_SUB, 1, 2, 0, 0, 0, i + 1, 6'(30 + i));
            cyc();
            check($sformatf("clrload%0d.op", i), 32'(alu_opcode), 0);
        end
        drive_idle();
        alu_cdb_valid = 1'b1; alu_cdb_rob_index = 6'd2; alu_cdb_res = 32'h9;
        cyc();
        check("clr.wake_op", 32'(alu_opcode), 0);
        drive_idle();
        clear = 1'b1;
        drive_issue(OP_AND, 0, 0, 1, 0, 0, 2, 33);
        cyc();
        $display("clear: alu_opcode=%0d full=%0b", alu_opcode, full);
        check("clr.edge_op", 32'(alu_opcode), 0);
        drive_idle();
        for (int i = 0; i < 4; i++) begin
            cyc();
            check($sformatf("clr.after%0d", i), 32'(alu_opcode), 0);
        end

        // rdy_in low freezes outputs and entries
        drive_idle();
        drive_issue(OP_XOR, 0, 0, 1, 0, 0, 2, 20);
        cyc();
        check("rdy.first_op", 32'(alu_opcode), 0);
        drive_issue(OP_OR, 0, 0, 3, 0, 0, 4, 21);
        cyc();
        check_pkt("rdy.pktA", OP_XOR, 1, 2, 20);
        rdy_in = 1'b0;
        drive_issue(OP_ADD, 0, 0, 5, 0, 0, 6, 22);
        alu_cdb_valid = 1'b1; alu_cdb_rob_index = 6'd3; alu_cdb_res = 32'hDEAD;
        for (int i = 0; i < 3; i++) begin
            cyc();
            $display("rdy low %0d: alu_opcode=%0d rob=%0d", i, alu_opcode, alu_rob_index);
            check_pkt($sformatf("rdy.hold%0d", i), OP_XOR, 1, 2, 20);
        end
        drive_idle();
        cyc();
        check_pkt("rdy.pktB", OP_OR, 3, 4, 21);
        cyc();
        check("rdy.dropped", 32'(alu_opcode), 0);

        // Randomized traffic against the reference model
        rst_in = 1'b1;
        #2;
        model_reset();
        @(posedge clk_in);
        #1 rst_in = 1'b0;
        for (int c = 0; c < 1600; c++) begin
            cdb_pct = ((c / 400) % 2 == 1) ? 12 : 50;
            rdy_in        = ($urandom_range(0, 9) != 0);
            clear         = ($urandom_range(0, 63) == 0);
            issue_valid   = ($urandom_range(0, 99) < 60);
            issue_opcode  = 6'($urandom_range(1, 63));
            issue_q1_busy = 1'($urandom_range(0, 1));
            issue_q2_busy = 1'($urandom_range(0, 1));
            issue_q1      = 6'($urandom_range(0, 7));
            issue_q2      = 6'($urandom_range(0, 7));
            issue_val1    = $urandom;
            issue_val2    = $urandom;
            issue_imm     = $urandom;
            issue_pc      = $urandom;
            issue_rob_index = 6'($urandom_range(0, 63));
            alu_cdb_valid = ($urandom_range(0, 99) < cdb_pct);
            lsb_cdb_valid = ($urandom_range(0, 99) < cdb_pct);
            alu_cdb_rob_index = 6'($urandom_range(0, 7));
            lsb_cdb_rob_index = 6'($urandom_range(0, 7));
            alu_cdb_res   = $urandom;
            lsb_cdb_res   = $urandom;
            #1;
            check($sformatf("rnd%0d.full", c), 32'(full), 32'(model_full()));
            model_step();
            cyc();
            if (alu_opcode != 6'd0)
                $display("rnd %0d: packet op=%0d rob=%0d val1=%h val2=%h", c, alu_opcode, alu_rob_index, alu_val1, alu_val2);
            check($sformatf("rnd%0d.op", c), 32'(alu_opcode), 32'(e_op));
            check($sformatf("rnd%0d.val1", c), alu_val1, e_v1);
            check($sformatf("rnd%0d.val2", c), alu_val2, e_v2);
            check($sformatf("rnd%0d.imm", c), alu_imm, e_imm);
            check($sformatf("rnd%0d.pc", c), alu_pc, e_pc);
            check($sformatf("rnd%0d.rob", c), 32'(alu_rob_index), 32'(e_rob));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
